// File: rtl/rca_config_unit_pkg.sv
// Shared types and constants for the RCA configuration unit.
// Holds the fixed datapath widths, the config op encoding, the FSM
// state type and the latched-request record.
package rca_config_unit_pkg;

    localparam int CPU_REG_ADDR_W     = 5;
    localparam int GRID_MUX_INPUTS    = 8;
    localparam int IO_UNIT_MUX_INPUTS = 6;
    localparam int NUM_IO_UNITS       = 5;
    localparam int NUM_GRID_SELS      = 60;
    localparam int NUM_IO_SELS        = 10;

    localparam int GRID_SEL_W   = $clog2(GRID_MUX_INPUTS);
    localparam int IO_SEL_W     = $clog2(IO_UNIT_MUX_INPUTS);
    localparam int RESULT_SEL_W = $clog2(NUM_IO_UNITS + 1);
    localparam int GRID_IDX_W   = $clog2(NUM_GRID_SELS);
    localparam int IO_IDX_W     = $clog2(NUM_IO_SELS);

    // Value of a result_sel entry that routes no IO unit to the write port.
    localparam int UNUSED_WRITE_PORT_ADDR = NUM_IO_UNITS;

    typedef enum logic [2:0] {
        OP_NONE       = 3'b000,
        OP_CPU_MAP    = 3'b001,
        OP_GRID_SEL   = 3'b010,
        OP_IO_SEL     = 3'b011,
        OP_RESULT_SEL = 3'b100,
        OP_IO_USE     = 3'b101,
        OP_RSVD       = 3'b110
    } rca_cfg_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_APPLY,
        ST_DONE
    } rca_cfg_state_t;

    // funct3 is kept raw: 3'b111 has no enum member but must still be held.
    typedef struct packed {
        logic [2:0]  funct3;
        logic [6:0]  rca;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        use_grid;   // 1: blocked by grid_busy, 0: by rca_busy[rca]
    } rca_cfg_req_t;

endpackage

// File: rtl/rca_config_legality_check.sv
// Combinational legality check of an incoming config instruction.
// Ports:
//   i_funct3, i_funct7, i_rs1_data, i_rs2_data : raw instruction fields
//   o_illegal       : request must be rejected with err
//   o_blocking_sel  : 1 = wait on grid_busy, 0 = wait on rca_busy[funct7]
module rca_config_legality_check
    import rca_config_unit_pkg::*;
#(
    parameter int NUM_RCAS        = 4,
    parameter int NUM_READ_PORTS  = 5,
    parameter int NUM_WRITE_PORTS = 5
) (
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    output logic        o_illegal,
    output logic        o_blocking_sel
);

    logic       w_rca_oob;
    logic [3:0] w_port;
    logic [3:0] w_port_cnt;

    assign w_rca_oob  = i_funct7 >= 7'(NUM_RCAS);
    assign w_port     = {1'b0, i_rs1_data[2:0]};
    // rs1[3] picks the destination map for CPU register mapping.
    assign w_port_cnt = i_rs1_data[3] ? 4'(NUM_WRITE_PORTS) : 4'(NUM_READ_PORTS);

    always_comb begin
        o_illegal      = 1'b0;
        o_blocking_sel = 1'b0;
        case (i_funct3)
            OP_CPU_MAP:    o_illegal = w_rca_oob || (w_port >= w_port_cnt);
            OP_GRID_SEL: begin
                o_illegal      = (i_rs1_data >= 32'(NUM_GRID_SELS)) ||
                                 (i_rs2_data >= 32'(GRID_MUX_INPUTS));
                o_blocking_sel = 1'b1;
            end
            OP_IO_SEL: begin
                o_illegal      = (i_rs1_data >= 32'(NUM_IO_SELS)) ||
                                 (i_rs2_data >= 32'(IO_UNIT_MUX_INPUTS));
                o_blocking_sel = 1'b1;
            end
            OP_RESULT_SEL: o_illegal = w_rca_oob ||
                                       (w_port >= 4'(NUM_WRITE_PORTS)) ||
                                       (i_rs2_data > 32'(NUM_IO_UNITS));
            OP_IO_USE:     o_illegal = w_rca_oob;
            default:       o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/rca_config_unit.sv
// RCA configuration unit: executes config instructions (funct3 001..101),
// holds the RCA configuration tables and drives them onto the datapath.
// A write waits while its RCA (or the shared grid) is busy, then commits
// and is acknowledged with a one-cycle done (err on rejection).
// Ports:
//   i_clk, i_rst_n (sync, active low)
//   i_issue_valid / o_issue_ready, i_funct3, i_funct7, i_rs1_data, i_rs2_data
//   i_rca_busy, i_grid_busy, i_flush : blocking and abort inputs
//   o_done, o_err                    : completion pulse
//   o_cpu_src_addr / o_cpu_dest_addr [rca][fb][port], o_grid_sel, o_io_sel,
//   o_result_sel [rca][fb][port], o_io_use [rca] : registered tables
module rca_config_unit
    import rca_config_unit_pkg::*;
#(
    parameter int NUM_RCAS        = 4,
    parameter int NUM_READ_PORTS  = 5,
    parameter int NUM_WRITE_PORTS = 5
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_issue_valid,
    output logic                      o_issue_ready,
    input  logic [2:0]                i_funct3,
    input  logic [6:0]                i_funct7,
    input  logic [31:0]               i_rs1_data,
    input  logic [31:0]               i_rs2_data,
    input  logic [NUM_RCAS-1:0]       i_rca_busy,
    input  logic                      i_grid_busy,
    input  logic                      i_flush,
    output logic                      o_done,
    output logic                      o_err,
    output logic [NUM_RCAS-1:0][1:0][NUM_READ_PORTS-1:0][CPU_REG_ADDR_W-1:0]  o_cpu_src_addr,
    output logic [NUM_RCAS-1:0][1:0][NUM_WRITE_PORTS-1:0][CPU_REG_ADDR_W-1:0] o_cpu_dest_addr,
    output logic [NUM_GRID_SELS-1:0][GRID_SEL_W-1:0]                          o_grid_sel,
    output logic [NUM_IO_SELS-1:0][IO_SEL_W-1:0]                              o_io_sel,
    output logic [NUM_RCAS-1:0][1:0][NUM_WRITE_PORTS-1:0][RESULT_SEL_W-1:0]   o_result_sel,
    output logic [NUM_RCAS-1:0][NUM_IO_UNITS-1:0]                             o_io_use
);

    localparam int RCA_IDX_W = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1;

    rca_cfg_state_t r_state;
    rca_cfg_req_t   r_req;
    logic           r_ready;
    logic           r_done;
    logic           r_err;

    logic [NUM_RCAS-1:0][1:0][NUM_READ_PORTS-1:0][CPU_REG_ADDR_W-1:0]  r_src;
    logic [NUM_RCAS-1:0][1:0][NUM_WRITE_PORTS-1:0][CPU_REG_ADDR_W-1:0] r_dest;
    logic [NUM_GRID_SELS-1:0][GRID_SEL_W-1:0]                          r_grid;
    logic [NUM_IO_SELS-1:0][IO_SEL_W-1:0]                              r_io;
    logic [NUM_RCAS-1:0][1:0][NUM_WRITE_PORTS-1:0][RESULT_SEL_W-1:0]   r_rsel;
    logic [NUM_RCAS-1:0][NUM_IO_UNITS-1:0]                             r_io_use;

    logic                 w_illegal;
    logic                 w_blk_sel;
    logic                 w_blk_in;
    logic                 w_blk_q;
    logic [RCA_IDX_W-1:0] w_rca_q;
    logic                 w_unused_bits;

    rca_config_legality_check #(
        .NUM_RCAS        (NUM_RCAS),
        .NUM_READ_PORTS  (NUM_READ_PORTS),
        .NUM_WRITE_PORTS (NUM_WRITE_PORTS)
    ) u_legal (
        .i_funct3       (i_funct3),
        .i_funct7       (i_funct7),
        .i_rs1_data     (i_rs1_data),
        .i_rs2_data     (i_rs2_data),
        .o_illegal      (w_illegal),
        .o_blocking_sel (w_blk_sel)
    );

    // Blocking at accept looks at the incoming fields; in WAIT it looks at
    // the latched request. An out-of-range funct7 is illegal anyway, so the
    // truncated index only matters for legal requests.
    assign w_blk_in = w_blk_sel ? i_grid_busy : i_rca_busy[i_funct7[RCA_IDX_W-1:0]];
    assign w_rca_q  = r_req.rca[RCA_IDX_W-1:0];
    assign w_blk_q  = r_req.use_grid ? i_grid_busy : i_rca_busy[w_rca_q];

    // Request bits no table write consumes.
    assign w_unused_bits = ^{r_req.rs1[31:6], r_req.rs2[31:5], r_req.rca[6:RCA_IDX_W]};

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_req   <= '0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_issue_valid && r_ready) begin
                        r_req   <= '{funct3: i_funct3, rca: i_funct7, rs1: i_rs1_data,
                                     rs2: i_rs2_data, use_grid: w_blk_sel};
                        r_ready <= 1'b0;
                        if (w_illegal) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                        end else if (w_blk_in) begin
                            r_state <= ST_WAIT;
                        end else begin
                            r_state <= ST_APPLY;
                        end
                    end
                end
                ST_WAIT: begin
                    // flush wins over the busy condition clearing this cycle
                    if (i_flush) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end else if (!w_blk_q) begin
                        r_state <= ST_APPLY;
                    end
                end
                ST_APPLY: begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    // Table writes commit on the APPLY cycle only; legality was settled at accept.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_src    <= '0;
            r_dest   <= '0;
            r_grid   <= '0;
            r_io     <= '0;
            r_io_use <= '0;
            for (int r = 0; r < NUM_RCAS; r++)
                for (int f = 0; f < 2; f++)
                    for (int p = 0; p < NUM_WRITE_PORTS; p++)
                        r_rsel[r][f][p] <= RESULT_SEL_W'(UNUSED_WRITE_PORT_ADDR);
        end else if (r_state == ST_APPLY) begin
            case (r_req.funct3)
                OP_CPU_MAP: begin
                    if (r_req.rs1[3])
                        r_dest[w_rca_q][r_req.rs1[4]][r_req.rs1[2:0]] <= r_req.rs2[CPU_REG_ADDR_W-1:0];
                    else
                        r_src[w_rca_q][r_req.rs1[4]][r_req.rs1[2:0]] <= r_req.rs2[CPU_REG_ADDR_W-1:0];
                end
                OP_GRID_SEL:   r_grid[r_req.rs1[GRID_IDX_W-1:0]] <= r_req.rs2[GRID_SEL_W-1:0];
                OP_IO_SEL:     r_io[r_req.rs1[IO_IDX_W-1:0]]     <= r_req.rs2[IO_SEL_W-1:0];
                OP_RESULT_SEL: r_rsel[w_rca_q][r_req.rs1[3]][r_req.rs1[2:0]] <= r_req.rs2[RESULT_SEL_W-1:0];
                OP_IO_USE:     r_io_use[w_rca_q] <= r_req.rs1[NUM_IO_UNITS-1:0];
                default: ;
            endcase
        end
    end

    assign o_issue_ready   = r_ready;
    assign o_done          = r_done;
    assign o_err           = r_err;
    assign o_cpu_src_addr  = r_src;
    assign o_cpu_dest_addr = r_dest;
    assign o_grid_sel      = r_grid;
    assign o_io_sel        = r_io;
    assign o_result_sel    = r_rsel;
    assign o_io_use        = r_io_use;

endmodule

// File: tb/tb_rca_config_unit.sv
// Directed bench for rca_config_unit: a vector table of single requests
// checked against a shadow copy of the tables, plus hand sequences for
// WAIT, flush, back-to-back issue and reset during WAIT.
module tb_rca_config_unit;
    import rca_config_unit_pkg::*;

    localparam int NR = 4;
    localparam int NP = 5;

    logic i_clk = 1'b0;
    logic i_rst_n, i_issue_valid, i_grid_busy, i_flush;
    logic o_issue_ready, o_done, o_err;
    logic [2:0]  i_funct3;
    logic [6:0]  i_funct7;
    logic [31:0] i_rs1_data, i_rs2_data;
    logic [NR-1:0] i_rca_busy;

    logic [NR-1:0][1:0][NP-1:0][CPU_REG_ADDR_W-1:0] src,  m_src;
    logic [NR-1:0][1:0][NP-1:0][CPU_REG_ADDR_W-1:0] dest, m_dest;
    logic [NUM_GRID_SELS-1:0][GRID_SEL_W-1:0]        grid, m_grid;
    logic [NUM_IO_SELS-1:0][IO_SEL_W-1:0]            io,   m_io;
    logic [NR-1:0][1:0][NP-1:0][RESULT_SEL_W-1:0]    rsel, m_rsel;
    logic [NR-1:0][NUM_IO_UNITS-1:0]                 iouse, m_iouse;

    int checks = 0;
    int failures = 0;

    rca_config_unit #(.NUM_RCAS(NR), .NUM_READ_PORTS(NP), .NUM_WRITE_PORTS(NP)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_issue_valid(i_issue_valid),
        .o_issue_ready(o_issue_ready), .i_funct3(i_funct3), .i_funct7(i_funct7),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_rca_busy(i_rca_busy),
        .i_grid_busy(i_grid_busy), .i_flush(i_flush), .o_done(o_done), .o_err(o_err),
        .o_cpu_src_addr(src), .o_cpu_dest_addr(dest), .o_grid_sel(grid),
        .o_io_sel(io), .o_result_sel(rsel), .o_io_use(iouse)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        exp_err;
    } vec_t;

    vec_t vecs[21];

    task automatic check(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic check_tables(input string tag);
        check({tag, ".src"},    src,   m_src);
        check({tag, ".dest"},   dest,  m_dest);
        check({tag, ".grid"},   grid,  m_grid);
        check({tag, ".io"},     io,    m_io);
        check({tag, ".rsel"},   rsel,  m_rsel);
        check({tag, ".io_use"}, iouse, m_iouse);
    endtask

    task automatic model_reset();
        m_src = '0; m_dest = '0; m_grid = '0; m_io = '0; m_iouse = '0;
        for (int r = 0; r < NR; r++)
            for (int f = 0; f < 2; f++)
                for (int p = 0; p < NP; p++)
                    m_rsel[r][f][p] = 3'd5;
    endtask

    task automatic model_write(input logic [2:0] f3, input logic [6:0] f7,
                               input logic [31:0] rs1, input logic [31:0] rs2);
        logic [1:0] r;
        r = f7[1:0];
        case (f3)
            3'b001: if (rs1[3]) m_dest[r][rs1[4]][rs1[2:0]] = rs2[4:0];
                    else        m_src[r][rs1[4]][rs1[2:0]]  = rs2[4:0];
            3'b010: m_grid[rs1[5:0]] = rs2[2:0];
            3'b011: m_io[rs1[3:0]]   = rs2[2:0];
            3'b100: m_rsel[r][rs1[3]][rs1[2:0]] = rs2[2:0];
            3'b101: m_iouse[r] = rs1[4:0];
            default: ;
        endcase
    endtask

    task automatic tick();
        @(posedge i_clk); #1;
    endtask

    // Issues one request (must be accepted on the next edge); returns the
    // cycle count from accept to done and the err seen with done.
    task automatic run_req(input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] rs1, input logic [31:0] rs2,
                           output int lat, output logic err, output logic got);
        i_funct3 = f3; i_funct7 = f7; i_rs1_data = rs1; i_rs2_data = rs2;
        i_issue_valid = 1'b1;
        tick();
        i_issue_valid = 1'b0;
        lat = 1; got = 1'b0; err = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (o_done) begin got = 1'b1; err = o_err; break; end
            tick();
            lat++;
        end
        if (got) tick();
    endtask

    initial begin
        int lat, n, dcnt;
        logic err, got;

        vecs[0]  = '{3'b001, 7'd2, 32'h18, 32'd7,  1'b0};
        vecs[1]  = '{3'b001, 7'd0, 32'h04, 32'h1F, 1'b0};
        vecs[2]  = '{3'b001, 7'd3, 32'h12, 32'h0A, 1'b0};
        vecs[3]  = '{3'b001, 7'd1, 32'h05, 32'd3,  1'b1};
        vecs[4]  = '{3'b001, 7'd1, 32'h0D, 32'd3,  1'b1};
        vecs[5]  = '{3'b001, 7'd4, 32'h00, 32'd3,  1'b1};
        vecs[6]  = '{3'b010, 7'd9, 32'd0,  32'd7,  1'b0};
        vecs[7]  = '{3'b010, 7'd0, 32'd60, 32'd1,  1'b1};
        vecs[8]  = '{3'b010, 7'd0, 32'd3,  32'd8,  1'b1};
        vecs[9]  = '{3'b011, 7'd0, 32'd4,  32'd1,  1'b0};
        vecs[10] = '{3'b011, 7'd0, 32'd10, 32'd1,  1'b1};
        vecs[11] = '{3'b011, 7'd0, 32'd2,  32'd6,  1'b1};
        vecs[12] = '{3'b100, 7'd4, 32'd1,  32'd2,  1'b1};
        vecs[13] = '{3'b100, 7'd1, 32'd1,  32'd6,  1'b1};
        vecs[14] = '{3'b100, 7'd1, 32'h09, 32'd3,  1'b0};
        vecs[15] = '{3'b100, 7'd2, 32'h05, 32'd1,  1'b1};
        vecs[16] = '{3'b101, 7'd0, 32'hFFFF_FFF5, 32'd0, 1'b0};
        vecs[17] = '{3'b101, 7'd7, 32'h1,  32'd0,  1'b1};
        vecs[18] = '{3'b000, 7'd0, 32'd0,  32'd0,  1'b1};
        vecs[19] = '{3'b110, 7'd0, 32'd0,  32'd0,  1'b1};
        vecs[20] = '{3'b111, 7'd0, 32'd0,  32'd0,  1'b1};

        i_rst_n = 1'b0; i_issue_valid = 1'b0; i_grid_busy = 1'b0; i_flush = 1'b0;
        i_funct3 = '0; i_funct7 = '0; i_rs1_data = '0; i_rs2_data = '0; i_rca_busy = '0;
        tick(); tick();
        i_rst_n = 1'b1;
        model_reset();
        check("reset.ready", o_issue_ready, 1'b1);
        check("reset.done",  o_done, 1'b0);
        check("reset.err",   o_err, 1'b0);
        check_tables("reset");

        foreach (vecs[i]) begin
            run_req(vecs[i].f3, vecs[i].f7, vecs[i].rs1, vecs[i].rs2, lat, err, got);
            check($sformatf("vec%0d.done", i), got, 1'b1);
            check($sformatf("vec%0d.err", i), err, vecs[i].exp_err);
            check($sformatf("vec%0d.latency", i), lat, vecs[i].exp_err ? 1 : 2);
            if (!vecs[i].exp_err) model_write(vecs[i].f3, vecs[i].f7, vecs[i].rs1, vecs[i].rs2);
            check_tables($sformatf("vec%0d", i));
        end

        // Grid write held in WAIT for 4 cycles by grid_busy.
        i_grid_busy = 1'b1;
        i_funct3 = 3'b010; i_funct7 = 7'd0; i_rs1_data = 32'd59; i_rs2_data = 32'd5;
        i_issue_valid = 1'b1;
        tick();
        i_issue_valid = 1'b0;
        dcnt = 0;
        for (int k = 0; k < 4; k++) begin
            if (o_issue_ready || o_done) dcnt++;
            tick();
        end
        check("wait.ready_or_done_while_busy", dcnt, 0);
        i_grid_busy = 1'b0;
        tick();
        check("wait.no_done_first", o_done, 1'b0);
        check("wait.grid_unchanged", grid, m_grid);
        tick();
        check("wait.done", o_done, 1'b1);
        check("wait.err", o_err, 1'b0);
        model_write(3'b010, 7'd0, 32'd59, 32'd5);
        check("wait.grid59", grid, m_grid);
        dcnt = 0;
        for (int k = 0; k < 3; k++) begin tick(); if (o_done) dcnt++; end
        check("wait.single_done", dcnt, 0);

        // Flush on the second WAIT cycle, busy clearing at the same time.
        i_rca_busy = 4'b1000;
        i_funct3 = 3'b101; i_funct7 = 7'd3; i_rs1_data = 32'hFFFF_FFF5; i_rs2_data = 32'd0;
        i_issue_valid = 1'b1;
        tick();
        i_issue_valid = 1'b0;
        check("flush.ready_in_wait", o_issue_ready, 1'b0);
        tick();
        i_flush = 1'b1; i_rca_busy = 4'b0000;
        tick();
        i_flush = 1'b0;
        check("flush.ready", o_issue_ready, 1'b1);
        dcnt = 0;
        for (int k = 0; k < 4; k++) begin if (o_done) dcnt++; tick(); end
        check("flush.no_done", dcnt, 0);
        check("flush.io_use", iouse, m_iouse);

        // Back-to-back IO selects with issue_valid held high.
        i_funct3 = 3'b011; i_funct7 = 7'd0; i_rs1_data = 32'd0; i_rs2_data = 32'd3;
        i_issue_valid = 1'b1;
        tick();
        i_rs1_data = 32'd9; i_rs2_data = 32'd5;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            if (o_issue_ready) break;
            tick();
            n++;
        end
        check("b2b.accept_spacing", n + 1, 3);
        tick();
        i_issue_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (o_done) begin got = 1'b1; break; end
            tick();
        end
        check("b2b.second_done", got, 1'b1);
        tick();
        model_write(3'b011, 7'd0, 32'd0, 32'd3);
        model_write(3'b011, 7'd0, 32'd9, 32'd5);
        check("b2b.io", io, m_io);

        // Reset while a request sits in WAIT.
        i_grid_busy = 1'b1;
        i_funct3 = 3'b011; i_rs1_data = 32'd1; i_rs2_data = 32'd2;
        i_issue_valid = 1'b1;
        tick();
        i_issue_valid = 1'b0;
        check("rstwait.in_wait", o_issue_ready, 1'b0);
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1; i_grid_busy = 1'b0;
        model_reset();
        check("rstwait.ready", o_issue_ready, 1'b1);
        check_tables("rstwait");
        dcnt = 0;
        for (int k = 0; k < 4; k++) begin if (o_done) dcnt++; tick(); end
        check("rstwait.no_done", dcnt, 0);
        check("rstwait.io", io, m_io);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rca_config_unit.md
Name: rca_config_unit

Overview:
- Executes the RCA configuration instructions (funct3 001–101) dispatched by the issue stage.
- Holds the architectural RCA configuration state: CPU register port maps, grid MUX selects, IO unit MUX selects, result MUX selects and IO input usage.
- Drives that state onto the RCA datapath.
- Defers a write while the targeted RCA or the shared grid is in use, then acknowledges completion with a done/err pulse.

Parameters:
- NUM_RCAS, 4, number of RCAs (valid funct7 range).
- NUM_READ_PORTS, 5, source ports per RCA.
- NUM_WRITE_PORTS, 5, destination ports per RCA.
- NUM_IO_UNITS, 5, IO units (equals GRID_NUM_ROWS).
- NUM_GRID_SELS, 60, grid MUX selects (NUM_GRID_MUXES*2, i.e. two inputs per PR slot).
- GRID_MUX_INPUTS, 8, legal grid select values 0..7.
- IO_UNIT_MUX_INPUTS, 6, legal IO MUX select values 0..5.
- NUM_IO_SELS, 10, IO unit MUX selects (GCI plus row MUX per IO unit).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- issue_valid  in  1  config instruction presented.
- issue_ready  out  1  unit can accept.
- funct3  in  3  instruction type.
- funct7  in  7  RCA index.
- rs1_data  in  32  selector / port field.
- rs2_data  in  32  value field.
- rca_busy  in  NUM_RCAS  per-RCA operation in flight.
- grid_busy  in  1  any RCA operation in flight on the shared grid.
- flush  in  1  abort a pending, not-yet-applied request.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid only with done; request was rejected.
- cpu_src_addr  out  NUM_RCAS*2*NUM_READ_PORTS*5  source register map, indexed [rca][fb][port].
- cpu_dest_addr  out  NUM_RCAS*2*NUM_WRITE_PORTS*5  destination register map, indexed [rca][fb][port].
- grid_sel  out  NUM_GRID_SELS*3  grid MUX selects.
- io_sel  out  NUM_IO_SELS*3  IO unit MUX selects.
- result_sel  out  NUM_RCAS*2*NUM_WRITE_PORTS*3  result MUX selects, indexed [rca][fb][port].
- io_use  out  NUM_RCAS*NUM_IO_UNITS  IO input usage mask.

Behaviour:
- Reset (rst_n=0 at posedge), also mid-operation:
  - state returns to IDLE; any captured request is discarded without done.
  - all addr fields = 0; grid_sel = 0; io_sel = 0; io_use = 0.
  - every result_sel = NUM_IO_UNITS (UNUSED_WRITE_PORT_ADDR).
  - done = 0, err = 0.
- FSM states: IDLE, WAIT, APPLY, DONE.
- issue_ready = 1 only in IDLE. Accept occurs on issue_valid & issue_ready; funct3, funct7, rs1 and rs2 are latched at accept.
- Legality is checked at accept. A request is illegal if:
  - funct3 is 000, 110 or 111;
  - funct7 >= NUM_RCAS for types 001, 100 or 101;
  - for 001: rs1[2:0] >= the relevant port count (rs1[3]=0 means source, NUM_READ_PORTS; rs1[3]=1 means dest, NUM_WRITE_PORTS);
  - for 010: rs1 >= NUM_GRID_SELS or rs2 >= GRID_MUX_INPUTS;
  - for 011: rs1 >= NUM_IO_SELS or rs2 >= IO_UNIT_MUX_INPUTS;
  - for 100: rs1[2:0] >= NUM_WRITE_PORTS or rs2 > NUM_IO_UNITS.
- Illegal request: IDLE goes to DONE with err=1. No table changes and no waiting.
- Blocking condition: grid_busy for 010/011; rca_busy[funct7] for 001/100/101.
- Legal request: IDLE goes to APPLY if unblocked at accept, otherwise to WAIT.
- WAIT:
  - re-evaluates the blocking condition each cycle; goes to APPLY when it clears.
  - flush=1 in WAIT goes to IDLE with no done and no write; flush takes priority over the condition clearing in the same cycle.
  - flush is ignored in all other states.
- APPLY: the table write commits at the end of this cycle, then the FSM goes to DONE. The blocking condition is not rechecked here.
- Table writes by type:
  - 001: rs1[4] = fb, rs1[3] = dest; writes rs2[4:0] into the addressed cpu_src_addr or cpu_dest_addr entry.
  - 100: rs1[3] = fb, rs1[2:0] = port; writes rs2[2:0] into result_sel.
  - 101: io_use[funct7] = rs1[NUM_IO_UNITS-1:0]; upper rs1 bits ignored.
- DONE: done=1 and err as determined; next state is IDLE.
- Latency:
  - accept at cycle N, unblocked: write visible at N+2, done at N+2, next accept at N+3.
  - illegal: done at N+1.
- Outputs come directly from registers; no combinational path from inputs to table outputs.

Decomposition:
- Shared package rca_config gains:
  - type enum rca_cfg_op_t (000..110);
  - widths CPU_REG_ADDR_W=5, GRID_SEL_W=$clog2(GRID_MUX_INPUTS), IO_SEL_W=$clog2(IO_UNIT_MUX_INPUTS), RESULT_SEL_W=$clog2(NUM_IO_UNITS+1);
  - NUM_GRID_SELS and NUM_IO_SELS constants;
  - a packed struct for the latched request.
- One sub-module: rca_config_legality_check, purely combinational, producing illegal and blocking_sel.

Test Plan:
- Reset, then read outputs -> all addr = 0, result_sel entries = 5, io_use = 0, issue_ready = 1, done = 0.
- funct3=001, funct7=2, rs1=0x18 (fb, dest, port 0), rs2=7, rca_busy=0 -> cpu_dest_addr[2][1][0]=7 at N+2, done=1, err=0, no other entry changed.
- funct3=010, rs1=59, rs2=5, grid_busy=1 for 4 cycles then 0 -> held in WAIT, issue_ready=0; grid_sel[59]=5 two cycles after grid_busy falls; done once.
- funct3=100, funct7=4, rs1=1, rs2=2 -> done=1, err=1 at N+1, no table change; repeat with funct7=1, rs2=6 -> err=1.
- funct3=101, funct7=3, rs1=0xFFFF_FFF5, rca_busy[3]=1, flush=1 on the 2nd wait cycle -> no done, io_use[3] remains 0, issue_ready=1 next cycle.
- Back-to-back 011 writes (rs1=0, rs2=3; rs1=9, rs2=5) with issue_valid held high -> accepts 3 cycles apart, io_sel[0]=3, io_sel[9]=5; assert rst_n=0 while in WAIT -> state IDLE, tables reset, no done.
